// File: rtl/two_way_karatsuba_ds.sv
`default_nettype none
// ============================================================================
// Module   : two_way_karatsuba_ds
// Brief    : Digit-serial two-way Karatsuba carry-less (GF(2)) multiplier with
//            start/busy/done handshake; D bits per cycle on each sub-product.
// Revision : 1.0 - initial release
// ============================================================================
module two_way_karatsuba_ds #(
    parameter int N = 571,
    parameter int D = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] c
);

    localparam int c_L  = N / 2;
    localparam int c_U  = N - c_L;
    localparam int c_K  = (c_U + D - 1) / D;
    localparam int c_W  = 2 * c_U - 1;
    localparam int c_CW = (c_K > 1) ? $clog2(c_K) : 1;
    localparam int c_CN = 2 * N;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_done;
    logic [c_CN-1:0] r_c;

    // Left operands shift right by D so bit j always holds operand bit k*D+j;
    // right operands shift left by D so they already carry the k*D offset.
    logic [c_U-1:0]  r_ahs, r_als, r_ams;
    logic [c_W-1:0]  r_bhs, r_bls, r_bms;
    logic [c_W-1:0]  r_ph, r_pl, r_pm;

    logic [c_U-1:0]  w_ah, w_al, w_bh, w_bl;
    logic [c_W-1:0]  w_ph_nx, w_pl_nx, w_pm_nx;
    logic [c_CN-1:0] w_ph_x, w_pl_x, w_pm_x, w_c;

    assign w_ah = a[N-1:c_L];
    assign w_al = c_U'(a[c_L-1:0]);
    assign w_bh = b[N-1:c_L];
    assign w_bl = c_U'(b[c_L-1:0]);

    always_comb begin
        w_ph_nx = r_ph;
        w_pl_nx = r_pl;
        w_pm_nx = r_pm;
        for (int j = 0; j < D; j++) begin
            if (r_ahs[j]) w_ph_nx = w_ph_nx ^ (r_bhs << j);
            if (r_als[j]) w_pl_nx = w_pl_nx ^ (r_bls << j);
            if (r_ams[j]) w_pm_nx = w_pm_nx ^ (r_bms << j);
        end
    end

    assign w_ph_x = c_CN'(r_ph);
    assign w_pl_x = c_CN'(r_pl);
    assign w_pm_x = c_CN'(r_pm);
    assign w_c    = (w_ph_x << (2 * c_L)) ^ ((w_pm_x ^ w_ph_x ^ w_pl_x) << c_L) ^ w_pl_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_c     <= '0;
            r_ahs   <= '0;
            r_als   <= '0;
            r_ams   <= '0;
            r_bhs   <= '0;
            r_bls   <= '0;
            r_bms   <= '0;
            r_ph    <= '0;
            r_pl    <= '0;
            r_pm    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ahs   <= w_ah;
                        r_als   <= w_al;
                        r_ams   <= w_ah ^ w_al;
                        r_bhs   <= c_W'(w_bh);
                        r_bls   <= c_W'(w_bl);
                        r_bms   <= c_W'(w_bh ^ w_bl);
                        r_ph    <= '0;
                        r_pl    <= '0;
                        r_pm    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_ph  <= w_ph_nx;
                    r_pl  <= w_pl_nx;
                    r_pm  <= w_pm_nx;
                    r_ahs <= r_ahs >> D;
                    r_als <= r_als >> D;
                    r_ams <= r_ams >> D;
                    r_bhs <= r_bhs << D;
                    r_bls <= r_bls << D;
                    r_bms <= r_bms << D;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CW'(c_K - 1)) r_state <= S_FIN;
                end
                S_FIN: begin
                    r_c     <= w_c;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign c    = r_c;

endmodule
`default_nettype wire

// File: tb/tb_two_way_karatsuba_ds.sv
`default_nettype none
// ============================================================================
// Module   : tb_two_way_karatsuba_ds
// Brief    : Bench for two_way_karatsuba_ds across four width/digit configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_two_way_karatsuba_ds;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         st0, st1, st2, st3;
    logic [7:0]   a0, b0;
    logic [6:0]   a1, b1;
    logic [570:0] a2, b2, a3, b3;
    logic         bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3;
    logic [15:0]  c0;
    logic [13:0]  c1;
    logic [1141:0] c2, c3;

    two_way_karatsuba_ds #(.N(8),   .D(2)) dut0 (.clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .busy(bz0), .done(dn0), .c(c0));
    two_way_karatsuba_ds #(.N(7),   .D(3)) dut1 (.clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .busy(bz1), .done(dn1), .c(c1));
    two_way_karatsuba_ds #(.N(571), .D(1)) dut2 (.clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .busy(bz2), .done(dn2), .c(c2));
    two_way_karatsuba_ds #(.N(571), .D(8)) dut3 (.clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .busy(bz3), .done(dn3), .c(c3));

    int checks = 0;
    int failures = 0;

    // Reference: schoolbook carry-less product, independent of Karatsuba split.
    function automatic logic [1141:0] clmul(input logic [570:0] x, input logic [570:0] y);
        logic [1141:0] r = '0;
        for (int i = 0; i < 571; i++)
            if (x[i]) r = r ^ ({571'b0, y} << i);
        return r;
    endfunction

    function automatic logic [570:0] rnd(input int nbits);
        logic [570:0] r = '0;
        for (int w = 0; w < 18; w++) r[w*32 +: 32] = $urandom;
        for (int i = nbits; i < 571; i++) r[i] = 1'b0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [1141:0] obs, input logic [1141:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [570:0] x, input logic [570:0] y);
        case (sel)
            0: begin st0 = s; a0 = x[7:0]; b0 = y[7:0]; end
            1: begin st1 = s; a1 = x[6:0]; b1 = y[6:0]; end
            2: begin st2 = s; a2 = x;      b2 = y;      end
            default: begin st3 = s; a3 = x; b3 = y; end
        endcase
    endtask

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return bz0;
            1: return bz1;
            2: return bz2;
            default: return bz3;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return dn0;
            1: return dn1;
            2: return dn2;
            default: return dn3;
        endcase
    endfunction

    function automatic logic [1141:0] get_c(input int sel);
        logic [1141:0] r = '0;
        case (sel)
            0: r[15:0] = c0;
            1: r[13:0] = c1;
            2: r = c2;
            default: r = c3;
        endcase
        return r;
    endfunction

    // One-cycle start, then wait (bounded) for done; checks latency, busy span and c.
    task automatic run(input int sel, input logic [570:0] x, input logic [570:0] y,
                       input logic [1141:0] exp_c, input int exp_lat, input string tag);
        int  lat = 0;
        int  nb;
        bit  seen = 0;
        drive(sel, 1'b1, x, y);
        @(posedge clk); #1;
        drive(sel, 1'b0, rnd(571), rnd(571));
        nb = int'(get_busy(sel));
        while (!seen && lat < 700) begin
            @(posedge clk); #1;
            lat++;
            if (get_done(sel)) seen = 1;
            else nb += int'(get_busy(sel));
        end
        check({tag, "_lat"},  1142'(lat), 1142'(exp_lat));
        check({tag, "_busy"}, 1142'(nb),  1142'(exp_lat));
        check({tag, "_c"},    get_c(sel), exp_c);
    endtask

    initial begin
        logic [570:0]  x, y;
        logic [1141:0] q[$];
        int            rem;
        bit            exp_done, seen;

        for (int s = 0; s < 4; s++) drive(s, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rst_busy%0d", s), 1142'(get_busy(s)), '0);
            check($sformatf("rst_done%0d", s), 1142'(get_done(s)), '0);
            check($sformatf("rst_c%0d", s),    get_c(s),           '0);
        end

        run(0, 571'h03, 571'h03, 1142'h0005, 3, "n8_3x3");
        run(0, 571'hFF, 571'h01, 1142'h00FF, 3, "n8_ffx01");
        run(0, 571'h80, 571'h80, 1142'h4000, 3, "n8_80x80");
        run(0, 571'hFF, 571'hFF, 1142'h5555, 3, "n8_ffxff");
        run(0, 571'h00, 571'hA5, 1142'h0000, 3, "n8_00xa5");

        run(1, 571'h7F, 571'h7F, 1142'h1555, 3, "n7_7fx7f");
        for (int i = 0; i < 1000; i++) begin
            x = rnd(7); y = rnd(7);
            run(1, x, y, clmul(x, y), 3, "n7_rand");
        end

        // Held start: accepted whenever idle, busy for K+1 cycles, done on the last.
        rem = 0;
        x = rnd(8); y = rnd(8);
        drive(0, 1'b1, x, y);
        for (int t = 0; t < 16; t++) begin
            exp_done = 0;
            if (rem == 0) begin
                q.push_back(clmul(x, y));
                rem = 3;
            end else begin
                rem--;
                if (rem == 0) exp_done = 1;
            end
            @(posedge clk); #1;
            check("hs_done", 1142'(get_done(0)), 1142'(exp_done));
            check("hs_busy", 1142'(get_busy(0)), 1142'(rem != 0));
            if (exp_done) check("hs_c", get_c(0), q.pop_front());
            x = rnd(8); y = rnd(8);
            drive(0, 1'b1, x, y);
        end
        drive(0, 1'b0, x, y);
        repeat (4) @(posedge clk);
        #1;

        // Reset on the second RUN cycle discards the operation.
        drive(0, 1'b1, 571'hFF, 571'hFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 571'h0, 571'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 1142'(get_busy(0)), '0);
        check("mid_rst_done", 1142'(get_done(0)), '0);
        check("mid_rst_c",    get_c(0),           '0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (get_done(0)) seen = 1;
        end
        check("mid_rst_no_done", 1142'(seen), '0);
        x = rnd(8); y = rnd(8);
        run(0, x, y, clmul(x, y), 3, "n8_after_rst");

        for (int i = 0; i < 3; i++) begin
            x = rnd(571); y = rnd(571);
            run(2, x, y, clmul(x, y), 287, "n571_d1");
            x = rnd(571); y = rnd(571);
            run(3, x, y, clmul(x, y), 37, "n571_d8");
        end
        x = {571{1'b1}};
        run(3, x, x, clmul(x, x), 37, "n571_d8_ones");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
